standoff_action_bank: RTL and testbench
=======================================

Name: standoff_action_bank

Overview:
- Multi-player, stateful successor to the per-choice validity check.
- Holds one ammo counter and one duck-streak counter per player.
- Latches each player's one-hot choice during a round and resolves all players together on a round strobe.
- Emits a validated 4-bit action per player and updates ammo. Sits between player/computer input logic and the round outcome/display logic.

Parameters:
- N_PLAYERS, 2, number of independent player channels (1..8).
- MAX_AMMO, 3, ammo counter ceiling; reload at this value is idle.
- INIT_AMMO, 0, ammo loaded into every channel at reset (must be <= MAX_AMMO).
- MAX_DUCKS, 2, maximum consecutive resolved ducks per player (used only with DUCK_LIMIT_EN).
- AW (derived, localparam), $clog2(MAX_AMMO+1), ammo counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- choice_in  in  3*N_PLAYERS  per-player one-hot choice, slice p = [3p+2:3p]; 100 shoot, 010 reload, 001 duck.
- choice_vld  in  N_PLAYERS  per-player strobe qualifying choice_in slice.
- round_tick  in  1  single-cycle strobe: resolve current round.
- final_choice  out  4*N_PLAYERS  registered per-player action, slice [4p+3:4p]; 0100 shoot, 0010 reload, 0001 duck, 1000 idle.
- final_vld  out  1  one-cycle pulse, final_choice/ammo valid for the resolved round.
- ammo  out  AW*N_PLAYERS  per-player current ammo count.
- locked  out  N_PLAYERS  per-player: choice already captured this round.

Behaviour:
- Reset (rst=1 at clk edge): ammo = INIT_AMMO all channels; duck streaks = 0; locked = 0; pending choices cleared; final_choice = 1000 all channels; final_vld = 0. Reset mid-round discards pending choices; no resolution occurs in a reset cycle even if round_tick=1.
- Capture: on choice_vld[p]=1 with locked[p]=0 and slice exactly one-hot, store slice and set locked[p] next cycle.
  - Non-one-hot slices (000, 011, 111, ...) are ignored; lock is not set.
  - First valid choice wins; later choice_vld[p] while locked is ignored.
- Resolution on round_tick=1:
  - Effective choice per player: pending choice if locked; else a valid choice presented the same cycle (bypass); else none.
  - Rule order per player:
    1. No choice -> idle.
    2. Shoot with ammo==0 -> idle.
    3. Reload with ammo==MAX_AMMO -> idle.
    4. Duck limited (see Optional Feature) -> idle.
    5. Otherwise the choice passes through.
  - Ammo update: shoot -> ammo-1; reload -> ammo+1; duck/idle -> unchanged. Computed from resolved action only, so no wrap or overflow is possible.
  - Duck streak: resolved duck -> streak+1, saturating at MAX_DUCKS; any other resolved action -> 0.
- Latency: final_choice, ammo and final_vld update on the edge after the round_tick cycle (1 cycle). final_vld is high exactly that one cycle. final_choice holds until the next resolution or reset.
- After resolution: all locked bits and pending choices clear on the same edge. A choice_vld in the round_tick cycle is consumed by this round, not carried to the next.
- Back-to-back round_tick: each is resolved independently; a round with no choices yields all idle.
- Channels are fully independent; no inter-player interaction in this block.

Optional Feature:
- Macro: STANDOFF_DUCK_LIMIT_EN.
- Defined: a duck resolving while streak==MAX_DUCKS becomes idle, and the streak resets to 0.
- Undefined: ducks are never limited and the streak counter is not implemented. MAX_DUCKS is unused.

Test Plan:
- Reset with INIT_AMMO=0, N_PLAYERS=2; P0 shoot, P1 reload, round_tick -> next cycle final_vld=1, P0=1000, P1=0010, ammo P0=0 P1=1.
- P0 reload x3 rounds (MAX_AMMO=3), then 4th reload -> 0010,0010,0010 then 1000; ammo 1,2,3,3.
- P0 valid 010, then 100 before round_tick -> locked[0]=1 after first; resolves reload (first wins); locked clears after resolution.
- choice_vld with slice 110, then round_tick -> idle 1000, locked stays 0; separately choice_vld and round_tick in same cycle with 001 -> duck resolved.
- With STANDOFF_DUCK_LIMIT_EN, MAX_DUCKS=2: P0 duck x4 rounds -> 0001,0001,1000,0001. Without the macro -> four 0001.
- rst asserted in the same cycle as round_tick with ammo=2 -> no final_vld; ammo=INIT_AMMO, final_choice all 1000, locked=0.

Source files
------------

// File: rtl/standoff_action_bank.sv
// standoff_action_bank: latches one-hot player choices, resolves every player on round_tick,
// and tracks per-player ammo. Optional macro STANDOFF_DUCK_LIMIT_EN caps consecutive ducks.
module standoff_action_bank #(
  parameter int N_PLAYERS = 2,
  parameter int MAX_AMMO  = 3,
  parameter int INIT_AMMO = 0,
  parameter int MAX_DUCKS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [3*N_PLAYERS-1:0]                  choice_in,
  input  logic [N_PLAYERS-1:0]                    choice_vld,
  input  logic                                    round_tick,
  output logic [4*N_PLAYERS-1:0]                  final_choice,
  output logic                                    final_vld,
  output logic [$clog2(MAX_AMMO+1)*N_PLAYERS-1:0] ammo,
  output logic [N_PLAYERS-1:0]                    locked
);

  localparam int            AW         = $clog2(MAX_AMMO+1);
  localparam logic [AW-1:0] AMMO_FULL  = AW'(MAX_AMMO);
  localparam logic [AW-1:0] AMMO_INIT  = AW'(INIT_AMMO);
  localparam logic [3:0]    ACT_IDLE   = 4'b1000;
  localparam logic [3:0]    ACT_SHOOT  = 4'b0100;
  localparam logic [3:0]    ACT_RELOAD = 4'b0010;
  localparam logic [3:0]    ACT_DUCK   = 4'b0001;

  logic [2:0]          pend_q   [N_PLAYERS];
  logic [2:0]          eff      [N_PLAYERS];
  logic [AW-1:0]       ammo_q   [N_PLAYERS];
  logic [AW-1:0]       ammo_nxt [N_PLAYERS];
  logic [3:0]          act_q    [N_PLAYERS];
  logic [3:0]          act_nxt  [N_PLAYERS];
  logic [N_PLAYERS-1:0] locked_q;
  logic [N_PLAYERS-1:0] cap;
  logic [N_PLAYERS-1:0] duck_block;
  logic                 final_vld_q;

  // Effective choice: a latched choice wins; otherwise a valid choice in the tick cycle bypasses.
  always_comb begin
    for (int p = 0; p < N_PLAYERS; p++) begin
      cap[p]      = choice_vld[p] && !locked_q[p] && $onehot(choice_in[3*p +: 3]);
      eff[p]      = locked_q[p] ? pend_q[p] : (cap[p] ? choice_in[3*p +: 3] : 3'b000);
      act_nxt[p]  = ACT_IDLE;
      ammo_nxt[p] = ammo_q[p];
      if (eff[p][2] && ammo_q[p] != '0) begin
        act_nxt[p]  = ACT_SHOOT;
        ammo_nxt[p] = ammo_q[p] - 1'b1;
      end else if (eff[p][1] && ammo_q[p] != AMMO_FULL) begin
        act_nxt[p]  = ACT_RELOAD;
        ammo_nxt[p] = ammo_q[p] + 1'b1;
      end else if (eff[p][0] && !duck_block[p]) begin
        act_nxt[p]  = ACT_DUCK;
      end
    end
  end

  // NOTE: the per-player arrays are a handful of flops, not a RAM, so they are reset like any
  // other state; all sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      final_vld_q <= 1'b0;
      locked_q    <= '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        pend_q[p] <= 3'b000;
        ammo_q[p] <= AMMO_INIT;
        act_q[p]  <= ACT_IDLE;
      end
    end else begin
      final_vld_q <= round_tick;
      if (round_tick) begin
        locked_q <= '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
          pend_q[p] <= 3'b000;
          ammo_q[p] <= ammo_nxt[p];
          act_q[p]  <= act_nxt[p];
        end
      end else begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (cap[p]) begin
            pend_q[p]   <= choice_in[3*p +: 3];
            locked_q[p] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef STANDOFF_DUCK_LIMIT_EN
  localparam int SW = $clog2(MAX_DUCKS+2);
  logic [SW-1:0] streak_q [N_PLAYERS];

  always_comb begin
    for (int p = 0; p < N_PLAYERS; p++) begin
      duck_block[p] = (streak_q[p] == SW'(MAX_DUCKS));
    end
  end

  // A blocked duck resolves idle, which clears the streak, so the count never exceeds MAX_DUCKS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_PLAYERS; p++) streak_q[p] <= '0;
    end else if (round_tick) begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        streak_q[p] <= (act_nxt[p] == ACT_DUCK) ? streak_q[p] + 1'b1 : '0;
      end
    end
  end
`else
  assign duck_block = '0;
  logic unused_max_ducks;
  assign unused_max_ducks = ^MAX_DUCKS;
`endif

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pack
    assign final_choice[4*p +: 4] = act_q[p];
    assign ammo[AW*p +: AW]       = ammo_q[p];
  end

  assign final_vld = final_vld_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_standoff_action_bank.sv
// tb_standoff_action_bank: randomized + directed stimulus against a choice-level reference model;
// a monitor process pops expected round results whenever final_vld is presented.
module tb_standoff_action_bank;

  localparam int N         = 2;
  localparam int MAX_AMMO  = 3;
  localparam int INIT_AMMO = 0;
  localparam int MAX_DUCKS = 2;
  localparam int AW        = $clog2(MAX_AMMO+1);

  localparam int NONE = 0, SHOOT = 1, RELOAD = 2, DUCK = 3, IDLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3*N-1:0]   choice_in = '0;
  logic [N-1:0]     choice_vld = '0;
  logic             round_tick = 1'b0;
  logic [4*N-1:0]   final_choice;
  logic             final_vld;
  logic [AW*N-1:0]  ammo;
  logic [N-1:0]     locked;

  standoff_action_bank #(
    .N_PLAYERS(N), .MAX_AMMO(MAX_AMMO), .INIT_AMMO(INIT_AMMO), .MAX_DUCKS(MAX_DUCKS)
  ) dut (
    .clk(clk), .rst(rst), .choice_in(choice_in), .choice_vld(choice_vld),
    .round_tick(round_tick), .final_choice(final_choice), .final_vld(final_vld),
    .ammo(ammo), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*N-1:0]  fc;
    logic [AW*N-1:0] am;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   m_ammo   [N];
  int   m_pend   [N];
  int   m_streak [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [2:0] s);
    case (s)
      3'b100:  return SHOOT;
      3'b010:  return RELOAD;
      3'b001:  return DUCK;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [3:0] encode(input int a);
    case (a)
      SHOOT:   return 4'b0100;
      RELOAD:  return 4'b0010;
      DUCK:    return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  // Monitor: every final_vld pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("final_vld", {63'd0, final_vld}, 64'd1);
      if (final_vld) begin
        check("final_choice", 64'(final_choice), 64'(e.fc));
        check("ammo", 64'(ammo), 64'(e.am));
      end
    end else if (final_vld) begin
      check("final_vld_spurious", 64'd1, 64'd0);
    end
  end

  // Drive one cycle of inputs, advance the model to the post-edge state, then step the clock.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [3*N-1:0] c,
                      input logic t);
    exp_t           e;
    int             req, eff, act;
    logic [N-1:0]   exp_locked;
    logic [4*N-1:0] idle_all;
    logic [AW*N-1:0] init_all;
    rst = r; choice_vld = v; choice_in = c; round_tick = t;
    if (r) begin
      for (int p = 0; p < N; p++) begin
        m_ammo[p] = INIT_AMMO; m_pend[p] = NONE; m_streak[p] = 0;
      end
    end else begin
      for (int p = 0; p < N; p++) begin
        req = v[p] ? decode(c[3*p +: 3]) : NONE;
        if (t) begin
          eff = (m_pend[p] != NONE) ? m_pend[p] : req;
          act = eff;
          if (eff == NONE) act = IDLE;
          else if (eff == SHOOT && m_ammo[p] == 0) act = IDLE;
          else if (eff == RELOAD && m_ammo[p] == MAX_AMMO) act = IDLE;
`ifdef STANDOFF_DUCK_LIMIT_EN
          else if (eff == DUCK && m_streak[p] == MAX_DUCKS) act = IDLE;
`endif
          if (act == SHOOT) m_ammo[p]--;
          if (act == RELOAD) m_ammo[p]++;
          m_streak[p] = (act == DUCK) ? m_streak[p] + 1 : 0;
          e.fc[4*p +: 4]   = encode(act);
          e.am[AW*p +: AW] = AW'(m_ammo[p]);
          m_pend[p] = NONE;
        end else if (m_pend[p] == NONE) begin
          m_pend[p] = req;
        end
      end
      if (t) begin
        e.due = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      exp_locked[p]       = (m_pend[p] != NONE);
      idle_all[4*p +: 4]  = 4'b1000;
      init_all[AW*p +: AW] = AW'(INIT_AMMO);
    end
    check("locked", 64'(locked), 64'(exp_locked));
    if (r) begin
      check("reset_final_vld", {63'd0, final_vld}, 64'd0);
      check("reset_final_choice", 64'(final_choice), 64'(idle_all));
      check("reset_ammo", 64'(ammo), 64'(init_all));
    end
  endtask

  initial begin
    logic [3*N-1:0] c;
    logic [N-1:0]   v;
    logic [2:0]     s;
    step(1, '0, '0, 0);
    step(1, '0, '0, 0);

    // P0 shoot with no ammo, P1 reload, presented in the tick cycle.
    step(0, 2'b11, {3'b010, 3'b100}, 1);
    check("tp1_final", 64'(final_choice), 64'({4'b0010, 4'b1000}));
    check("tp1_ammo", 64'(ammo), 64'({2'd1, 2'd0}));

    // P0 reload four rounds: the fourth hits the ceiling.
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b01, {3'b000, 3'b010}, 0);
      step(0, '0, '0, 1);
    end
    check("tp2_final_p0", 64'(final_choice[3:0]), 64'(4'b1000));
    check("tp2_ammo_p0", 64'(ammo[AW-1:0]), 64'(3));

    // Shoot to 2, then first-wins latch: reload then shoot before the tick.
    step(0, 2'b01, {3'b000, 3'b100}, 1);
    step(0, 2'b01, {3'b000, 3'b010}, 0);
    step(0, 2'b01, {3'b000, 3'b100}, 0);
    step(0, '0, '0, 1);
    check("tp3_final_p0", 64'(final_choice[3:0]), 64'(4'b0010));

    // Non-one-hot slice is ignored; then a same-cycle duck is resolved.
    step(0, 2'b01, {3'b000, 3'b110}, 0);
    step(0, '0, '0, 1);
    check("tp4_idle_p0", 64'(final_choice[3:0]), 64'(4'b1000));
    step(0, 2'b01, {3'b000, 3'b001}, 1);
    check("tp4_duck_p0", 64'(final_choice[3:0]), 64'(4'b0001));
    step(0, '0, '0, 1);

    // Four duck rounds (limit behaviour depends on the macro).
    for (int i = 0; i < 4; i++) step(0, 2'b01, {3'b000, 3'b001}, 1);

    // Reset coinciding with a tick while P0 holds ammo 2.
    step(0, 2'b01, {3'b000, 3'b100}, 1);
    step(0, 2'b11, {3'b010, 3'b100}, 0);
    step(1, 2'b11, {3'b010, 3'b100}, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < N; p++) begin
        case ($urandom_range(0, 9))
          0, 1:    s = 3'b100;
          2, 3, 4: s = 3'b010;
          5, 6:    s = 3'b001;
          default: s = 3'($urandom_range(0, 7));
        endcase
        c[3*p +: 3] = s;
        v[p] = ($urandom_range(0, 2) != 0);
      end
      step(($urandom_range(0, 60) == 0), v, c, ($urandom_range(0, 3) == 0));
    end

    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
